// File: rtl/dac_ramp_feeder.sv
// Slews the MCP47FEB channel code toward an accepted target by at most STEP
// codes per completed DAC write (falling edge of dac_busy).
module dac_ramp_feeder #(
    parameter int CODE_W         = 12,
    parameter int MAX_CODE       = 4095,
    parameter int STEP           = 64,
    parameter int INIT_CODE      = 0,
    parameter int SETTLE_UPDATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] target_value,
    input  logic        target_valid,
    output logic        target_ready,
    input  logic        dac_busy,
    output logic [15:0] ch_value,
    output logic        at_target,
    output logic        ramping
);
    localparam int CW1   = CODE_W + 1;
    localparam int CNT_W = (SETTLE_UPDATES < 1) ? 1 : $clog2(SETTLE_UPDATES + 1);

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_target;
    logic [CNT_W-1:0]    r_settle_cnt;
    logic                r_busy_d;
    logic                r_at_target;
    logic                r_ramping;

    logic                w_slot;
    logic                w_accept;
    logic                w_differs;
    logic                w_in_reach;
    logic                w_last_settle;
    logic [CODE_W-1:0]   w_clamped;
    logic [CW1-1:0]      w_diff;
    logic [CW1-1:0]      w_abs;

    // A slot is the end of a DAC write, so code only moves between transactions.
    assign w_slot       = r_busy_d & ~dac_busy;
    assign target_ready = (r_state != RAMP) & ~rst;
    assign w_accept     = target_valid & target_ready;

    always_comb begin
        w_clamped = target_value[CODE_W-1:0];
        if (target_value > 16'(MAX_CODE))
            w_clamped = CODE_W'(MAX_CODE);
    end

    assign w_differs     = (w_clamped != r_code);
    assign w_diff        = {1'b0, r_target} - {1'b0, r_code};
    assign w_abs         = w_diff[CODE_W] ? (~w_diff + 1'b1) : w_diff;
    assign w_in_reach    = (w_abs <= CW1'(STEP));
    assign w_last_settle = ((int'(r_settle_cnt) + 1) >= SETTLE_UPDATES);

    always_comb begin
        ch_value             = '0;
        ch_value[CODE_W-1:0] = r_code;
    end

    assign at_target = r_at_target;
    assign ramping   = r_ramping;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_code       <= CODE_W'(INIT_CODE);
            r_target     <= CODE_W'(INIT_CODE);
            r_settle_cnt <= '0;
            r_busy_d     <= 1'b0;
            r_at_target  <= 1'b1;
            r_ramping    <= 1'b0;
        end else begin
            r_busy_d <= dac_busy;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_target <= w_clamped;
                        if (w_differs) begin
                            r_state     <= RAMP;
                            r_ramping   <= 1'b1;
                            r_at_target <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (w_slot) begin
                        if (w_in_reach) begin
                            r_code       <= r_target;
                            r_settle_cnt <= '0;
                            r_ramping    <= 1'b0;
                            if (SETTLE_UPDATES == 0) begin
                                r_state     <= IDLE;
                                r_at_target <= 1'b1;
                            end else begin
                                r_state <= SETTLE;
                            end
                        end else if (w_diff[CODE_W]) begin
                            r_code <= r_code - CODE_W'(STEP);
                        end else begin
                            r_code <= r_code + CODE_W'(STEP);
                        end
                    end
                end
                SETTLE: begin
                    // A new target takes priority over a coincident slot.
                    if (w_accept) begin
                        r_target     <= w_clamped;
                        r_settle_cnt <= '0;
                        if (w_differs) begin
                            r_state   <= RAMP;
                            r_ramping <= 1'b1;
                        end
                    end else if (w_slot) begin
                        if (w_last_settle) begin
                            r_state      <= IDLE;
                            r_at_target  <= 1'b1;
                            r_settle_cnt <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dac_ramp_feeder.md
Name: dac_ramp_feeder

Overview:
- Upstream stage of the MCP47FEB I2C DAC writer.
- Accepts target codes over a valid/ready handshake and drives the 16-bit ch_value word the DAC writer transmits.
- Slews ch_value toward the target by at most STEP codes per completed DAC write, which bounds output slew on the analogue side.
- Reports when the output has settled at the target.

Parameters:
- CODE_W, 12: DAC resolution in bits; ch_value[CODE_W-1:0] carries the code, upper bits are 0.
- MAX_CODE, 4095: clamp ceiling for accepted targets.
- STEP, 64: maximum code change per DAC update slot (1..MAX_CODE).
- INIT_CODE, 0: code driven after reset.
- SETTLE_UPDATES, 2: update slots to wait after reaching target before at_target asserts (0 = immediate).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- target_value  in  16  requested code; values above MAX_CODE are clamped
- target_valid  in  1  target_value valid
- target_ready  out  1  block accepts target this cycle
- dac_busy  in  1  busy flag from the DAC writer
- ch_value  out  16  value presented to the DAC writer, {zeros, code}
- at_target  out  1  output equals target and settle count elapsed
- ramping  out  1  high while in RAMP

Behaviour:
- Reset (rst=1 at a clk edge):
  - code=INIT_CODE, target=INIT_CODE, busy_d=0, settle_cnt=0, state=IDLE.
  - Outputs: ch_value={0,INIT_CODE}, at_target=1, ramping=0, target_ready=0 during the reset cycle.
  - Reset mid-ramp discards the target and returns to INIT_CODE on the next edge.
- Update slot:
  - slot = busy_d & ~dac_busy, where busy_d is dac_busy registered each cycle; slot is the falling edge of busy.
  - code, and hence ch_value, changes only on a cycle with slot=1. It is therefore stable for a full DAC transaction.
- Accept:
  - target_ready = (state != RAMP) & ~rst.
  - Transfer occurs when target_valid & target_ready.
  - Target register loads min(target_value, MAX_CODE).
- States:
  - IDLE:
    - at_target=1.
    - On accept: if the clamped target equals code, stay in IDLE with no output change; otherwise go to RAMP and clear at_target on the same edge.
  - RAMP:
    - ramping=1.
    - On slot with diff = target - code, computed signed at CODE_W+1 bits: if |diff| <= STEP then code <= target and go to SETTLE (or IDLE if SETTLE_UPDATES=0); else code <= code ± STEP toward target.
    - Accepts are blocked.
  - SETTLE:
    - Counts slots; after SETTLE_UPDATES slots go to IDLE and set at_target.
    - An accept in SETTLE with a target different from code clears settle_cnt and goes to RAMP.
    - An accept with target equal to code restarts the settle count.
- Simultaneous events:
  - Accept and slot in the same cycle in IDLE/SETTLE: the accept wins and the state goes to RAMP; the first step happens on the next slot, not the current one.
  - A slot on the same edge as leaving RAMP is consumed by the final step.
- Arithmetic:
  - No overflow or underflow: a step never crosses the target.
  - The target is already clamped to 0..MAX_CODE, so code stays within 0..MAX_CODE.
- Latency:
  - ch_value updates one clk after the slot-detect edge (registered output).
  - at_target rises on the edge that ends the last settle slot.

Test Plan:
- STEP=64, INIT=0, SETTLE=2; accept 0x0100; pulse busy high then low 6 times -> ch_value 0x0040, 0x0080, 0x00C0, 0x0100; at_target=1 after 2 further slots; ramping low after the 4th slot.
- From 0x0FC0, accept 0x1234 -> target clamped to 0x0FFF; one slot -> ch_value 0x0FFF (partial step 63), never exceeds 0x0FFF.
- From 0x0100, accept 0x00A0 -> slots give 0x00C0, then 0x00A0; no undershoot.
- target_valid held with 0x0200 during RAMP -> target_ready=0, target unchanged; ch_value constant while dac_busy=1 for 500 cycles.
- In SETTLE at 0x0100, accept 0x0000 on the same cycle as a slot -> state RAMP, ch_value stays 0x0100 that cycle, next slot gives 0x00C0.
- rst=1 for one cycle mid-ramp at 0x0080 toward 0x0400 -> next edge ch_value=0x0000, at_target=1, target_ready=1 the cycle after reset deasserts.
